spi_ahb_fifo_bridge: RTL
========================

Name: spi_ahb_fifo_bridge

Overview:
AHB-Lite slave that sits between the system bus and the byte-level SPI master core. It is a buffered, parametrised bridge.
- Writes to DATA queue words in a TX FIFO.
- A launcher FSM feeds the SPI core one word per transfer using the spi_ready_send/spi_busy handshake.
- Words received by the SPI core are captured into an RX FIFO, and DATA reads pop from it.
- STATUS and CTRL registers expose FIFO levels, sticky overflow flags, RX enable and flush.

Parameters:
DATA_W, 8, SPI word width (1..16)
TX_DEPTH, 4, TX FIFO depth in words (power of 2, 2..128)
RX_DEPTH, 4, RX FIFO depth in words (power of 2, 2..128)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
hsel  in  1  slave select
htrans  in  2  AHB transfer type; bit1=1 means NONSEQ/SEQ
hwrite  in  1  1=write
haddr  in  32  byte address; bits[3:2] decoded
hwdata  in  32  write data (valid in data phase)
hrdata  out  32  read data (valid in data phase)
hready  out  1  tied 1, no wait states
spi_data_out  in  DATA_W  word received by the SPI core
spi_busy  in  1  SPI core transfer in progress
spi_data_in  out  DATA_W  word to transmit
spi_ready_send  out  1  transfer request to the SPI core

Behaviour:
- Address phase:
  - When hsel && htrans[1] && hready: register hwrite and haddr[3:2] into a_wr, a_reg, and set a_vld.
  - Otherwise clear a_vld.
- Data phase is the cycle after the address phase. All write side effects occur on the clk edge ending the data phase.
- Register map (undecoded addresses: reads return 0, writes ignored):
  - 0x0 DATA
    - Write: push hwdata[DATA_W-1:0] into TX. If TX is full, drop the word and set tx_ovf.
    - Read: hrdata = zero-extended RX head; pop at end of data phase. If RX is empty, return 0 and do not pop.
  - 0x4 STATUS (read-only), bits:
    - bit0 tx_full
    - bit1 tx_empty
    - bit2 rx_full
    - bit3 rx_empty
    - bit4 spi_busy
    - bit5 rx_ovf
    - bit6 tx_ovf
    - bit7 launcher not IDLE
    - [15:8] tx_count
    - [23:16] rx_count
    - all other bits 0
  - 0x8 CTRL, bits:
    - bit0 rx_en: R/W, reset 1
    - bit1 clear both ovf flags: write-1 pulse, reads 0
    - bit2 flush both FIFOs: write-1 pulse, reads 0
- hrdata is combinational from the data-phase registers and the current FIFO/flag state. It is 0 when a_vld=0.
- FIFOs:
  - Circular with wrapping pointers; counts are $clog2(DEPTH)+1 bits.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This also holds when full (pop frees the slot) and when empty is not possible for pop.
- Launcher FSM:
  - IDLE:
    - If TX not empty && !spi_busy: spi_data_in <= TX head, pop TX, spi_ready_send <= 1, go to REQ.
  - REQ:
    - Hold spi_ready_send=1 until spi_busy=1, then spi_ready_send <= 0 and go to XFER.
  - XFER:
    - Wait for spi_busy=0, then go to IDLE.
  - Back-to-back throughput: the next launch can occur the cycle after returning to IDLE.
- RX capture:
  - busy_q registers spi_busy. When busy_q && !spi_busy && rx_en, push spi_data_out into RX.
  - RX full at capture: drop the word and set rx_ovf.
  - Capture is independent of launcher state, so transfers initiated elsewhere are also captured.
- Flush:
  - Zeroes both FIFO pointers and counts.
  - Does not abort an in-flight REQ/XFER. spi_data_in is held.
  - A capture in the same cycle as the flush is discarded.
  - A DATA write in the same cycle as the flush is discarded.
- Sticky flags:
  - Overflow flags stay set until a CTRL bit1 write or rst.
  - Set and clear in the same cycle: set wins.
- Reset values:
  - spi_data_in=0, spi_ready_send=0, FSM=IDLE.
  - FIFOs empty, rx_en=1, tx_ovf=rx_ovf=0.
  - a_vld=0, busy_q=0, hrdata=0, hready=1.
- Reset mid-transfer: outputs drop to reset values on the next edge. Buffered data is lost.

Test Plan:
- Single write: write 0xA5 to 0x0 -> spi_ready_send rises 2 cycles after the address phase with spi_data_in=0xA5. It falls the cycle after the model raises spi_busy. TX returns to empty.
- Burst and TX overflow (DEPTH=4, SPI model held busy): write 0x01..0x06 -> TX holds 4 of the queued words, STATUS[6]=1. On release, the SPI model receives 0x01..0x05 in order (0x01 launched before busy) and 0x06 is dropped.
- RX path: SPI model returns 0x3C then 0xC3 on two busy falling edges -> STATUS rx_count=2. Reads of 0x0 return 0x3C then 0xC3. A third read returns 0 and STATUS[3]=1.
- RX overflow and clear: 5 captures with RX_DEPTH=4 -> rx_count=4, STATUS[5]=1. Write 0x2 to 0x8 -> STATUS[5]=0, data unchanged.
- Flush and rx_en: with 3 TX words queued during busy, write 0x4 to 0x8 -> tx_count=0 and no further launches. Write 0x0 to CTRL, then capture -> rx_count unchanged.
- Reset mid-REQ: assert rst while spi_ready_send=1 -> next edge spi_ready_send=0, spi_data_in=0, STATUS=0x0000000A with spi_busy low.

Source files
------------

// File: rtl/spi_ahb_fifo_bridge.sv
// AHB-Lite slave bridging bus words to a byte-level SPI master core through
// TX/RX FIFOs, with a launcher FSM driving the spi_ready_send/spi_busy handshake.

module spi_ahb_fifo_bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty/count gate every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

module spi_ahb_fifo_bridge #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [31:0]       haddr,
  input  logic [31:0]       hwdata,
  output logic [31:0]       hrdata,
  output logic              hready,
  input  logic [DATA_W-1:0] spi_data_out,
  input  logic              spi_busy,
  output logic [DATA_W-1:0] spi_data_in,
  output logic              spi_ready_send
);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER} launch_state_t;

  launch_state_t     state;
  logic              a_vld, a_wr;
  logic [1:0]        a_reg;
  logic              busy_q, rx_en, tx_ovf, rx_ovf;

  logic              wr_data, rd_data, wr_ctrl, flush, ovf_clr;
  logic              launch, capture, rx_pop, tx_ovf_set, rx_ovf_set;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic [TCW-1:0]    tx_count;
  logic [RCW-1:0]    rx_count;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              unused_bits;

  assign hready      = 1'b1;
  assign unused_bits = ^{haddr[31:4], haddr[1:0], htrans[0], hwdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld <= 1'b0;
      a_wr  <= 1'b0;
      a_reg <= 2'd0;
    end else begin
      a_vld <= hsel && htrans[1] && hready;
      if (hsel && htrans[1] && hready) begin
        a_wr  <= hwrite;
        a_reg <= haddr[3:2];
      end
    end
  end

  assign wr_data = a_vld &&  a_wr && (a_reg == 2'd0);
  assign rd_data = a_vld && !a_wr && (a_reg == 2'd0);
  assign wr_ctrl = a_vld &&  a_wr && (a_reg == 2'd2);
  assign flush   = wr_ctrl && hwdata[2];
  assign ovf_clr = wr_ctrl && hwdata[1];

  // Launches are suppressed during a flush so a discarded word is never sent.
  assign launch     = (state == IDLE) && !tx_empty && !spi_busy && !flush;
  assign capture    = busy_q && !spi_busy && rx_en;
  assign rx_pop     = rd_data && !rx_empty;
  assign tx_ovf_set = wr_data && !flush && tx_full && !launch;
  assign rx_ovf_set = capture && !flush && rx_full && !rx_pop;

  spi_ahb_fifo_bridge_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (wr_data && !flush),
    .pop   (launch),
    .wdata (hwdata[DATA_W-1:0]),
    .rdata (tx_head),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  spi_ahb_fifo_bridge_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (capture && !flush),
    .pop   (rx_pop),
    .wdata (spi_data_out),
    .rdata (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      spi_ready_send <= 1'b0;
      spi_data_in    <= '0;
    end else begin
      case (state)
        IDLE: if (launch) begin
          spi_data_in    <= tx_head;
          spi_ready_send <= 1'b1;
          state          <= REQ;
        end
        REQ: if (spi_busy) begin
          spi_ready_send <= 1'b0;
          state          <= XFER;
        end
        XFER: if (!spi_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Overflow flags are sticky; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      rx_en  <= 1'b1;
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      busy_q <= spi_busy;
      if (wr_ctrl) rx_en <= hwdata[0];
      if (tx_ovf_set)   tx_ovf <= 1'b1;
      else if (ovf_clr) tx_ovf <= 1'b0;
      if (rx_ovf_set)   rx_ovf <= 1'b1;
      else if (ovf_clr) rx_ovf <= 1'b0;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns hrdata and no latch is inferred.
    hrdata = '0;
    if (a_vld && !a_wr) begin
      case (a_reg)
        2'd0: if (!rx_empty) hrdata[DATA_W-1:0] = rx_head;
        2'd1: hrdata = {8'd0, 8'(rx_count), 8'(tx_count), (state != IDLE), tx_ovf,
                        rx_ovf, spi_busy, rx_empty, rx_full, tx_empty, tx_full};
        2'd2: hrdata = {31'd0, rx_en};
        default: ;
      endcase
    end
  end
endmodule
